mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous RAM between the pipelined core's instruction fetch port and its MEM-stage data port. Data accesses take priority over fetches, because the data access belongs to the older instruction. While either requester waits, the block raises a stall that freezes the core's PC and pipeline registers. It sits between the core top level and the unified program/data RAM.

## Interface
Parameters:
- AW, 10, RAM word-address width; RAM depth = 2^AW words of 32 bits.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_valid.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_rdata  out  32  fetched word.
- i_valid  out  1  fetch completion pulse.
- d_rd  in  1  data read request; held until d_valid.
- d_wr  in  1  data write request; held until d_valid.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data.
- d_valid  out  1  data completion pulse.
- stall  out  1  freeze the core pipeline.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address, taken from addr[AW+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en.
- misalign_err  out  1  sticky misaligned-data-access flag.
- conflict_cnt  out  CNT_W  saturating count of fetch-denied cycles.

## Operation
FSM states: IDLE, I_WAIT, D_WAIT.
- IDLE, d_rd or d_wr: grant data. Drive ram_en=1, ram_we=d_wr, ram_addr=d_addr[AW+1:2], ram_wdata=d_wdata. Go to D_WAIT.
- IDLE, i_req only: grant fetch. Drive ram_en=1, ram_we=0, ram_addr=i_addr[AW+1:2]. Go to I_WAIT.
- IDLE, no request: ram_en=0. Stay in IDLE.
- D_WAIT: d_valid=1. For a read, d_rdata=ram_rdata and the value is also captured into d_hold. Go to IDLE.
- I_WAIT: i_valid=1, i_rdata=ram_rdata; the value is also captured into i_hold. Go to IDLE.
- Outside the WAIT states, i_rdata=i_hold and d_rdata=d_hold.
- No new grant is issued in a WAIT state. A requester's request is still asserted in its completion cycle and must not be reissued. Maximum throughput is therefore one access per 2 cycles.
- d_rd and d_wr both high: treated as a write.
- Misaligned data access (d_addr[1:0]≠0):
  - The grant still goes to D_WAIT, but ram_en=0 and no write occurs.
  - d_valid pulses in D_WAIT and d_rdata=32'h0.
  - misalign_err is set and stays set until reset.
- stall = (i_req & ~i_valid) | ((d_rd|d_wr) & ~d_valid). It is combinational.
- conflict_cnt increments in each IDLE cycle where i_req and a data request are both high and the data request wins. It saturates at all-ones.
- Address bits above AW+1 are ignored, so out-of-range addresses wrap modulo the RAM size.

## Timing
- Reset values: state=IDLE, i_hold=32'h00000013 (NOP), d_hold=0, misalign_err=0, conflict_cnt=0. All handshake and RAM outputs are 0, except i_rdata=32'h00000013.
- Latency: a grant in cycle N produces the valid pulse in cycle N+1. The requester advances on the edge ending N+1.
- Contention: a fetch that arrives together with a data request completes at N+3 (data granted at N, fetch granted at N+2).
- Reset during a WAIT state: the pending access is dropped with no valid pulse. ram_en and ram_we go to 0 immediately (asynchronously).
- A request withdrawn before its grant is never issued. Withdrawal after the grant is unsupported.

## Structure
- Package mem_arb_pkg holds: the state enum typedef (IDLE, I_WAIT, D_WAIT), the localparam NOP_INSTR=32'h00000013, and the localparam for the misaligned-read return value 32'h0.
- Single module. The conflict counter is a small always_ff inside it; no sub-module.

## Test plan
- Reset, then fetch i_addr=0x8 with ram_rdata=0x00500093: ram_addr=2 at N; i_valid=1, i_rdata=0x00500093 at N+1; stall=0 at N+2.
- Simultaneous i_req (addr 0x10) and d_rd (addr 0x40): data granted first, d_valid at N+1, i_valid at N+3, conflict_cnt=1.
- d_wr to 0x44 with d_wdata=0xDEADBEEF: ram_we=1, ram_addr=0x11 at N; a subsequent d_rd of 0x44 returns 0xDEADBEEF.
- d_rd at 0x42: no ram_en, d_valid at N+1 with d_rdata=0, misalign_err=1, and it stays set after further accesses.
- Reset asserted during D_WAIT: ram_en=0 immediately, no d_valid, i_rdata=0x00000013 after release.
- 2^CNT_W+5 contention events: conflict_cnt saturates at all-ones.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: idle (grant point) or waiting one cycle for RAM read data.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_t;

    // addi x0, x0, 0 -- fetch return value before any fetch has completed.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Load data returned for a misaligned data read.
    localparam logic [31:0] MISALIGN_RDATA = 32'h00000000;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the instruction fetch
// port and the MEM-stage data port. Data wins ties (older instruction).
// Each access is a grant cycle followed by a completion cycle, during which
// no other grant is issued, so throughput is one access every two cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW    = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic [31:0]      i_rdata,
    output logic             i_valid,
    input  logic             d_rd,
    input  logic             d_wr,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic [31:0]      d_rdata,
    output logic             d_valid,
    output logic             stall,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    output logic             misalign_err,
    output logic [CNT_W-1:0] conflict_cnt
);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic [31:0]       i_hold_reg;
    logic [31:0]       d_hold_reg;
    logic              d_read_reg;     // pending data access is a load
    logic              d_mis_reg;      // pending data access is misaligned
    logic              misalign_err_reg;
    logic [CNT_W-1:0]  conflict_cnt_reg;

    logic              d_req;
    logic              d_mis;
    logic              grant_d;
    logic              ram_en_next;
    logic              ram_we_next;
    logic [AW-1:0]     ram_addr_next;
    logic [31:0]       ram_wdata_next;

    // Address bits outside the word index are intentionally ignored.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2]};

    assign d_req   = d_rd | d_wr;
    assign d_mis   = (d_addr[1:0] != 2'b00);
    assign grant_d = (state_reg == IDLE) && d_req;

    // Grant selection, RAM command and completion-cycle output muxing.
    always_comb begin
        state_next     = state_reg;
        ram_en_next    = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = '0;
        ram_wdata_next = '0;
        i_valid        = 1'b0;
        d_valid        = 1'b0;
        i_rdata        = i_hold_reg;
        d_rdata        = d_hold_reg;
        case (state_reg)
            IDLE: begin
                if (d_req) begin
                    // Misaligned accesses still complete, but never touch the RAM.
                    ram_en_next    = ~d_mis;
                    ram_we_next    = d_wr & ~d_mis;
                    ram_addr_next  = d_addr[AW+1:2];
                    ram_wdata_next = d_wdata;
                    state_next     = D_WAIT;
                end else if (i_req) begin
                    ram_en_next    = 1'b1;
                    ram_addr_next  = i_addr[AW+1:2];
                    state_next     = I_WAIT;
                end
            end
            I_WAIT: begin
                i_valid    = 1'b1;
                i_rdata    = ram_rdata;
                state_next = IDLE;
            end
            D_WAIT: begin
                d_valid = 1'b1;
                if (d_mis_reg) begin
                    d_rdata = MISALIGN_RDATA;
                end else if (d_read_reg) begin
                    d_rdata = ram_rdata;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // RAM command is forced quiet while reset is held, even with requests pending.
    always_comb begin
        ram_en    = ram_en_next & reset;
        ram_we    = ram_we_next & reset;
        ram_addr  = reset ? ram_addr_next : '0;
        ram_wdata = reset ? ram_wdata_next : '0;
    end

    // Stall while any request has not yet seen its completion pulse.
    assign stall = (i_req & ~i_valid) | (d_req & ~d_valid);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Remember the kind of data access granted, for the completion cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_read_reg <= 1'b0;
            d_mis_reg  <= 1'b0;
        end else if (grant_d) begin
            d_read_reg <= ~d_wr;
            d_mis_reg  <= d_mis;
        end
    end

    // Hold the last fetched word and last load result between accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_hold_reg <= NOP_INSTR;
            d_hold_reg <= '0;
        end else begin
            if (state_reg == I_WAIT) begin
                i_hold_reg <= ram_rdata;
            end
            if ((state_reg == D_WAIT) && d_read_reg) begin
                d_hold_reg <= d_mis_reg ? MISALIGN_RDATA : ram_rdata;
            end
        end
    end

    // Sticky misaligned-data-access flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err_reg <= 1'b0;
        end else if (grant_d && d_mis) begin
            misalign_err_reg <= 1'b1;
        end
    end

    // Saturating count of cycles where a fetch lost to a data access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt_reg <= '0;
        end else if (grant_d && i_req && !(&conflict_cnt_reg)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
        end
    end

    assign misalign_err = misalign_err_reg;
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural RAM
// and per-port scoreboards of expected read data.
module tb_mem_port_arbiter;

    localparam int AW    = 10;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_req;
    logic [31:0]      i_addr;
    logic [31:0]      i_rdata;
    logic             i_valid;
    logic             d_rd;
    logic             d_wr;
    logic [31:0]      d_addr;
    logic [31:0]      d_wdata;
    logic [31:0]      d_rdata;
    logic             d_valid;
    logic             stall;
    logic             ram_en;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic             misalign_err;
    logic [CNT_W-1:0] conflict_cnt;

    typedef struct {
        bit          chk;
        logic [31:0] val;
    } exp_t;

    exp_t i_q[$];
    exp_t d_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_port_arbiter #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_valid      (i_valid),
        .d_rd         (d_rd),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .stall        (stall),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .misalign_err (misalign_err),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Contents of a RAM word that has never been written.
    function automatic logic [31:0] ram_init(input logic [AW-1:0] a);
        if (a == 10'd2) return 32'h00500093;
        return {16'hA5A5, 6'b0, a};
    endfunction

    // Behavioural single-port RAM: read data valid the cycle after ram_en.
    logic [31:0]     mem [0:(1<<AW)-1];
    logic [(1<<AW)-1:0] written;
    always @(posedge clk) begin
        if (!reset) begin
            written <= '0;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end
            ram_rdata <= written[ram_addr] ? mem[ram_addr] : ram_init(ram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop expected read data on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (d_valid) begin
            n_cmp++;
            assert (d_q.size() != 0) else begin
                n_bad++;
                $error("FAIL d_valid_unexpected: observed pulse expected none");
            end
            if (d_q.size() != 0) begin
                e = d_q.pop_front();
                if (e.chk) check("d_rdata", d_rdata, e.val);
            end
        end
        if (i_valid) begin
            n_cmp++;
            assert (i_q.size() != 0) else begin
                n_bad++;
                $error("FAIL i_valid_unexpected: observed pulse expected none");
            end
            if (i_q.size() != 0) begin
                e = i_q.pop_front();
                if (e.chk) check("i_rdata", i_rdata, e.val);
            end
        end
    end

    // Wait (bounded) for a completion pulse; lat = cycle index relative to N.
    task automatic wait_valid(input bit is_i, input int k0, output int lat);
        lat = -1;
        for (int k = k0; k < k0 + 20; k++) begin
            @(negedge clk);
            if (is_i ? i_valid : d_valid) begin
                lat = k;
                return;
            end
        end
    endtask

    // Caller is just after a rising edge; that cycle is the grant cycle N.
    task automatic i_fetch(input logic [31:0] addr, input logic [31:0] expv);
        int lat;
        i_req  = 1'b1;
        i_addr = addr;
        i_q.push_back('{1'b1, expv});
        @(negedge clk);
        check("fetch_ram_en", ram_en, 1'b1);
        check("fetch_ram_addr", ram_addr, addr[AW+1:2]);
        wait_valid(1'b1, 1, lat);
        check("fetch_latency", lat, 1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic d_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit chk, input logic [31:0] expv);
        int   lat;
        logic aligned;
        aligned = (addr[1:0] == 2'b00);
        d_rd    = rd;
        d_wr    = wr;
        d_addr  = addr;
        d_wdata = wdata;
        d_q.push_back('{chk, expv});
        @(negedge clk);
        check("data_ram_en", ram_en, aligned);
        check("data_ram_we", ram_we, aligned & wr);
        if (aligned) check("data_ram_addr", ram_addr, addr[AW+1:2]);
        wait_valid(1'b0, 1, lat);
        check("data_latency", lat, 1);
        @(posedge clk); #1;
        d_rd = 1'b0;
        d_wr = 1'b0;
    endtask

    task automatic contention(input logic [31:0] ia, input logic [31:0] da);
        int lat;
        i_req  = 1'b1;
        i_addr = ia;
        d_rd   = 1'b1;
        d_addr = da;
        d_q.push_back('{1'b1, ram_init(da[AW+1:2])});
        i_q.push_back('{1'b1, ram_init(ia[AW+1:2])});
        @(negedge clk);
        check("cont_stall", stall, 1'b1);
        check("cont_ram_addr", ram_addr, da[AW+1:2]);
        wait_valid(1'b0, 1, lat);
        check("cont_d_latency", lat, 1);
        @(posedge clk); #1;
        d_rd = 1'b0;
        wait_valid(1'b1, 2, lat);
        check("cont_i_latency", lat, 3);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    initial begin
        exp_t dropped;
        reset   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_i_rdata", i_rdata, 32'h00000013);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_valids", {i_valid, d_valid, ram_en, ram_we, stall}, 5'b0);
        check("rst_misalign", misalign_err, 1'b0);
        check("rst_conflict", conflict_cnt, 0);
        reset = 1'b1;

        // Single fetch.
        @(posedge clk); #1;
        i_fetch(32'h8, 32'h00500093);
        @(negedge clk);
        check("fetch_stall_after", stall, 1'b0);
        check("fetch_hold", i_rdata, 32'h00500093);

        // Fetch and data read collide: data first.
        @(posedge clk); #1;
        contention(32'h10, 32'h40);
        check("conflict_one", conflict_cnt, 1);

        // Store then load back, including a wrapped address.
        d_access(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 1'b0, 32'h0);
        d_access(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'hDEADBEEF);
        d_access(1'b1, 1'b0, 32'h1000_0044, 32'h0, 1'b1, 32'hDEADBEEF);

        // Both d_rd and d_wr: a write.
        d_access(1'b1, 1'b1, 32'h50, 32'h0BADF00D, 1'b0, 32'h0);
        d_access(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 32'h0BADF00D);

        // Misaligned read and misaligned write.
        d_access(1'b1, 1'b0, 32'h42, 32'h0, 1'b1, 32'h0);
        check("misalign_set", misalign_err, 1'b1);
        d_access(1'b0, 1'b1, 32'h45, 32'h12345678, 1'b0, 32'h0);
        d_access(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'hDEADBEEF);
        i_fetch(32'h20, ram_init(10'h8));
        check("misalign_sticky", misalign_err, 1'b1);

        // Reset while a data read is in D_WAIT: access dropped.
        d_rd   = 1'b1;
        d_addr = 32'h48;
        d_q.push_back('{1'b1, ram_init(10'h12)});
        @(posedge clk); #1;
        reset   = 1'b0;
        dropped = d_q.pop_back();
        #1;
        check("rstw_ram_en", ram_en, 1'b0);
        check("rstw_ram_we", ram_we, 1'b0);
        check("rstw_d_valid", d_valid, 1'b0);
        @(negedge clk);
        check("rstw_d_valid_neg", d_valid, 1'b0);
        d_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstw_i_rdata", i_rdata, 32'h00000013);
        check("rstw_misalign", misalign_err, 1'b0);
        check("rstw_conflict", conflict_cnt, 0);
        check("rstw_stall", stall, 1'b0);

        // Saturation of the conflict counter: 2^CNT_W + 5 events.
        @(posedge clk); #1;
        for (int k = 1; k <= (1 << CNT_W) + 5; k++) begin
            contention(32'h100 + 32'(4 * k), 32'h200 + 32'(4 * k));
            check("conflict_sat", conflict_cnt, (k >= 15) ? 15 : k);
        end

        repeat (2) @(negedge clk);
        check("i_q_drained", i_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
